// File: rtl/peripheral_spram_wb_master.sv
// peripheral_spram_wb_master
//
// Wishbone B3 master that turns a command stream (start byte address, beat
// count, direction) into linear incrementing accesses toward a single-port
// RAM slave. Write data is staged in an internal FIFO and the access only
// starts once the whole burst is buffered, so the bus never stalls on write
// data. Read data is forwarded beat by beat as acks return.
//
// Build option:
//   PERIPHERAL_SPRAM_WB_MASTER_BURST_EN defined   : one registered burst per
//     command, CTI 010 ... 111 (000 for single beats).
//   PERIPHERAL_SPRAM_WB_MASTER_BURST_EN undefined : every beat is a classic
//     cycle, CTI 000, with one idle bus cycle (GAP) between beats.
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o     command handshake (accepted only in IDLE)
//   cmd_we_i, cmd_adr_i, cmd_len_i  direction, start byte address, beats-1
//   wdat_valid_i/wdat_ready_o, wdat_i  write-data stream into the FIFO
//   rdat_valid_o, rdat_o        read-data stream, no backpressure
//   done_o, err_o               completion pulse and abort flag
//   wb_*                        Wishbone B3 master port

module peripheral_spram_wb_master #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int LW        = $clog2(MAX_BURST)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,

  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [LW-1:0] cmd_len_i,

  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  input  logic [DW-1:0] wdat_i,

  output logic          rdat_valid_o,
  output logic [DW-1:0] rdat_o,

  output logic          done_o,
  output logic          err_o,

  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  // state | meaning
  // ------+----------------------------------------------------------
  // IDLE  | ready for a command
  // FILL  | write command latched, waiting for len+1 words in the FIFO
  // XFER  | cyc/stb asserted, one beat per ack
  // GAP   | classic mode only: one idle bus cycle between beats

  localparam int CW = LW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_XFER = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] rem_q;
  logic          done_q;
  logic          err_q;

  logic [DW-1:0] fifo_mem [MAX_BURST];
  logic [LW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;

  logic          cmd_take;
  logic          beat_ack;
  logic          beat_err;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [LW-1:0] wr_idx;
  logic [CW-1:0] fill_need;
  logic          xfer;

  assign xfer      = (state_q == S_XFER);
  assign fill_need = CW'(len_q) + CW'(1);

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_take = 1'b0;
    beat_ack = 1'b0;
    beat_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          cmd_take = 1'b1;
          state_d  = cmd_we_i ? S_FILL : S_XFER;
        end
      end
      S_FILL: begin
        if (fifo_cnt_q >= fill_need) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // err has priority over a simultaneous ack and counts no beat
        if (wb_err_i) begin
          beat_err = 1'b1;
          state_d  = S_IDLE;
        end else if (wb_ack_i) begin
          beat_ack = 1'b1;
          if (rem_q == '0) begin
            state_d = S_IDLE;
          end else begin
`ifdef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
            state_d = S_XFER;
`else
            state_d = S_GAP;
`endif
          end
        end
      end
      S_GAP: begin
        state_d = S_XFER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Command / beat datapath
  // ---------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q   <= 1'b0;
      adr_q  <= '0;
      len_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (cmd_take) begin
        we_q  <= cmd_we_i;
        adr_q <= cmd_adr_i & {{(AW-2){1'b1}}, 2'b00};
        len_q <= cmd_len_i;
        rem_q <= cmd_len_i;
      end else if (beat_ack) begin
        adr_q <= adr_q + AW'(4);
        rem_q <= rem_q - LW'(1);
      end
      done_q <= beat_err | (beat_ack & (rem_q == '0));
      err_q  <= beat_err;
    end
  end

  // ---------------------------------------------------------------
  // Write-data FIFO
  // ---------------------------------------------------------------
  assign fifo_full  = (fifo_cnt_q == CW'(MAX_BURST));
  assign fifo_push  = wdat_valid_i & ~fifo_full;
  assign fifo_pop   = beat_ack & we_q;
  assign fifo_flush = beat_err;
  // A word pushed in the flush cycle becomes the first entry of the
  // emptied FIFO rather than being lost.
  assign wr_idx     = fifo_flush ? '0 : wr_ptr_q;

  always_ff @(posedge wb_clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_idx] <= wdat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (fifo_flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= fifo_push ? LW'(1) : '0;
      fifo_cnt_q <= fifo_push ? CW'(1) : '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + LW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + LW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign cmd_ready_o  = (state_q == S_IDLE);
  assign wdat_ready_o = ~fifo_full;

  assign wb_cyc_o = xfer;
  assign wb_stb_o = xfer;
  assign wb_we_o  = xfer & we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = 4'hF;
  assign wb_bte_o = 2'b00;
  assign wb_dat_o = (fifo_cnt_q != '0) ? fifo_mem[rd_ptr_q] : '0;

`ifdef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
  assign wb_cti_o = (xfer && (len_q != '0)) ?
                    ((rem_q != '0) ? 3'b010 : 3'b111) : 3'b000;
`else
  assign wb_cti_o = 3'b000;
`endif

  assign rdat_valid_o = wb_ack_i & wb_cyc_o & ~wb_we_o;
  assign rdat_o       = wb_dat_i;

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_peripheral_spram_wb_master.sv
// Testbench for peripheral_spram_wb_master: RAM-like Wishbone slave model,
// scoreboard of expected bus beats / read words / completions, and a
// negedge monitor that checks them as the DUT presents them.

module tb_peripheral_spram_wb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int LW = 4;

`ifdef PERIPHERAL_SPRAM_WB_MASTER_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          wdat_valid_i = 1'b0;
  logic          wdat_ready_o;
  logic [DW-1:0] wdat_i = '0;
  logic          rdat_valid_o;
  logic [DW-1:0] rdat_o;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic [1:0]    wb_bte_o;
  logic [2:0]    wb_cti_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [DW-1:0] wb_dat_i;

  peripheral_spram_wb_master #(.AW(AW), .DW(DW), .MAX_BURST(MB), .LW(LW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- slave model ----------------
  logic [31:0] ram [64];
  logic [15:0] cyc_cnt = '0;
  int          beat_no = 0;
  int          err_at = -1;
  logic        stall_mode = 1'b0;
  logic        ack_en;

  always_comb begin
    ack_en   = !stall_mode || cyc_cnt[0];
    wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
    wb_err_i = wb_cyc_o & wb_stb_o & ack_en & (beat_no == err_at);
    wb_dat_i = ram[wb_adr_o[7:2]];
  end

  always @(posedge wb_clk_i) begin
    cyc_cnt <= cyc_cnt + 16'd1;
    if (wb_ack_i && !wb_err_i) begin
      beat_no <= beat_no + 1;
      if (wb_we_o) ram[wb_adr_o[7:2]] <= wb_dat_o;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]  adr;
    logic        we;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        mon_en = 1'b1;
  logic        pend_gap = 1'b0;
  logic        pend_done = 1'b0;
  logic        pend_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_cti(input int len, input int i);
    logic [2:0] c;
    c = 3'b000;
    if (len != 0) c = (i == len) ? 3'b111 : 3'b010;
    return BURST_ON ? c : 3'b000;
  endfunction

  always @(negedge wb_clk_i) begin
    beat_t b;
    if (!wb_rst_ni || !mon_en) begin
      pend_gap  = 1'b0;
      pend_done = 1'b0;
      beat_q.delete();
      rd_q.delete();
    end else begin
      if (pend_gap) begin
        chk("gap_cyc", 32'(wb_cyc_o), 32'(BURST_ON));
        pend_gap = 1'b0;
      end
      if (pend_done) begin
        chk("done", 32'(done_o), 1);
        chk("done_err", 32'(err_o), 32'(pend_err));
        chk("cyc_after_last", 32'(wb_cyc_o), 0);
        pend_done = 1'b0;
        done_cnt++;
      end else if (done_o) begin
        chk("spurious_done", 32'(done_o), 0);
      end
      if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
        chk("beat_expected", 32'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          chk("beat_adr", 32'(wb_adr_o), 32'(b.adr));
          chk("beat_we", 32'(wb_we_o), 32'(b.we));
          chk("beat_cti", 32'(wb_cti_o), 32'(b.cti));
          chk("beat_err", 32'(wb_err_i), 32'(b.err));
          chk("beat_stb", 32'(wb_stb_o), 1);
          if (b.we) chk("beat_wdat", wb_dat_o, b.dat);
          if (b.err || b.last) begin
            pend_done = 1'b1;
            pend_err  = b.err;
          end else begin
            pend_gap = 1'b1;
          end
        end
      end
      if (rdat_valid_o) begin
        chk("rdat_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) chk("rdat", rdat_o, rd_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wb_clk_i);
      wdat_valid_i = 1'b1;
      wdat_i       = base + 32'(i);
    end
    @(negedge wb_clk_i);
    wdat_valid_i = 1'b0;
  endtask

  task automatic expect_cmd(input logic we, input logic [7:0] adr, input int len,
                            input logic [31:0] dbase, input int err_idx);
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.adr  = adr + 8'(4 * i);
      b.we   = we;
      b.dat  = dbase + 32'(i);
      b.cti  = exp_cti(len, i);
      b.last = (i == len);
      b.err  = (i == err_idx);
      beat_q.push_back(b);
      if (b.err) break;
      if (!we) rd_q.push_back(dbase + 32'(i));
    end
  endtask

  task automatic issue_cmd(input logic we, input logic [7:0] adr, input logic [3:0] len);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = len;
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 300 && done_cnt < target; k++) @(posedge wb_clk_i);
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int acc;
    int nb;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_adr", 32'(wb_adr_o), 0);
    chk("rst_we", 32'(wb_we_o), 0);
    chk("rst_cti", 32'(wb_cti_o), 0);
    chk("rst_bte", 32'(wb_bte_o), 0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 1);
    chk("rst_wdat_ready", 32'(wdat_ready_o), 1);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_rdat_valid", 32'(rdat_valid_o), 0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    // 4-beat write with data buffered first
    push_words(32'hA0, 4);
    expect_cmd(1'b1, 8'h10, 3, 32'hA0, -1);
    issue_cmd(1'b1, 8'h10, 4'd3);
    chk("fill_cycle_cyc", 32'(wb_cyc_o), 0);
    @(posedge wb_clk_i);
    #1;
    chk("xfer_after_fill_cyc", 32'(wb_cyc_o), 1);
    wait_done(1);

    // read-back
    expect_cmd(1'b0, 8'h10, 3, 32'hA0, -1);
    issue_cmd(1'b0, 8'h10, 4'd3);
    chk("read_cyc_next_cycle", 32'(wb_cyc_o), 1);
    wait_done(2);

    // single beat
    push_words(32'h55, 1);
    expect_cmd(1'b1, 8'h40, 0, 32'h55, -1);
    issue_cmd(1'b1, 8'h40, 4'd0);
    wait_done(3);

    // address wrap with slave wait states, then read back
    stall_mode = 1'b1;
    push_words(32'hB0, 4);
    expect_cmd(1'b1, 8'hF8, 3, 32'hB0, -1);
    issue_cmd(1'b1, 8'hF8, 4'd3);
    wait_done(4);
    stall_mode = 1'b0;
    expect_cmd(1'b0, 8'hF8, 3, 32'hB0, -1);
    issue_cmd(1'b0, 8'hF8, 4'd3);
    wait_done(5);

    // error (with simultaneous ack) on the 2nd beat of a 4-beat write
    push_words(32'hC0, 4);
    err_at = beat_no + 1;
    expect_cmd(1'b1, 8'h20, 3, 32'hC0, 1);
    issue_cmd(1'b1, 8'h20, 4'd3);
    wait_done(6);
    err_at = -1;

    // FIFO must have been flushed: exactly 16 words fit
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge wb_clk_i);
      wdat_valid_i = 1'b1;
      wdat_i       = 32'hD0 + 32'(acc);
      if (wdat_ready_o) acc++;
    end
    @(negedge wb_clk_i);
    wdat_valid_i = 1'b0;
    chk("fifo_accepted", 32'(acc), 16);
    chk("fifo_full_ready", 32'(wdat_ready_o), 0);

    // reset mid-read-burst
    mon_en = 1'b0;
    nb = beat_no;
    issue_cmd(1'b0, 8'h10, 4'd3);
    for (int k = 0; k < 50 && !(wb_cyc_o && beat_no > nb); k++) begin
      @(posedge wb_clk_i);
      #1;
    end
    chk("pre_reset_cyc", 32'(wb_cyc_o), 1);
    #2;
    wb_rst_ni = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(wb_cyc_o), 0);
    chk("async_rst_stb", 32'(wb_stb_o), 0);
    chk("async_rst_fifo_ready", 32'(wdat_ready_o), 1);
    chk("async_rst_cmd_ready", 32'(cmd_ready_o), 1);
    chk("async_rst_adr", 32'(wb_adr_o), 0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    mon_en = 1'b1;

    // FIFO empty after reset: fresh data must come out first
    push_words(32'hE0, 2);
    expect_cmd(1'b1, 8'h80, 1, 32'hE0, -1);
    issue_cmd(1'b1, 8'h80, 4'd1);
    wait_done(7);
    expect_cmd(1'b0, 8'h80, 1, 32'hE0, -1);
    issue_cmd(1'b0, 8'h80, 4'd1);
    wait_done(8);

    repeat (3) @(posedge wb_clk_i);
    chk("beat_queue_drained", 32'(beat_q.size()), 0);
    chk("rdat_queue_drained", 32'(rd_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
